vscpu_mem_hs: RTL

- Parametrised successor to the team's multicycle memory-to-memory CPU, using the same 8-opcode ISA (register and immediate forms).
- Word width and address width are parameters.
- Memory is reached through a req/ack handshake with arbitrary wait states, replacing fixed one-cycle RAM timing.
- Adds a halt detector, a retire strobe and a compile-time-optional multiplier. Sits between the program/data RAM (or arbiter) and the top level.

---
 rtl/vscpu_mem_hs.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/vscpu_mem_hs.sv
// Multicycle memory-to-memory CPU; every state is one req/ack memory access.
// Optional: define VSCPU_MUL_EN to implement op 7 as MUL/MULi (otherwise op 7 is a NOP).
module vscpu_mem_hs #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              retire,
  output logic              halted,
  output logic [ADDR_W-1:0] pc
);
  localparam int IW_W  = 2*ADDR_W + 4;
  localparam int OP_LO = 2*ADDR_W + 1;
  localparam int IMM_B = 2*ADDR_W;
  localparam logic [DATA_W-1:0] DW_V = DATA_W'(DATA_W);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_NAND = 3'd1;
  localparam logic [2:0] OP_SRL  = 3'd2;
  localparam logic [2:0] OP_LT   = 3'd3;
  localparam logic [2:0] OP_CP   = 3'd4;
  localparam logic [2:0] OP_CPI  = 3'd5;
  localparam logic [2:0] OP_BZJ  = 3'd6;
`ifdef VSCPU_MUL_EN
  localparam logic [2:0] OP_MUL  = 3'd7;
`endif

  typedef enum logic [2:0] {S_FETCH, S_RD1, S_RD2, S_RD3, S_WB, S_HALT} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [IW_W-1:0]     iw_q, iw_d;
  logic [DATA_W-1:0]   r1_q, r1_d, r2_q, r2_d;
  logic                run_q;

  logic [2:0]          op_q, op_f;
  logic                imm_q, imm_f;
  logic [ADDR_W-1:0]   fa_q, fb_q, pc_inc, r1_addr, bzji_tgt, bzj_tgt;
  logic [DATA_W-1:0]   fb_ext, alu_x, alu_res;
  logic                go, acc;

  function automatic logic is_alu(input logic [2:0] op);
`ifdef VSCPU_MUL_EN
    return !op[2] || (op == OP_MUL);
`else
    return !op[2];
`endif
  endfunction

  assign op_q     = iw_q[IW_W-1:OP_LO];
  assign imm_q    = iw_q[IMM_B];
  assign fa_q     = iw_q[IMM_B-1:ADDR_W];
  assign fb_q     = iw_q[ADDR_W-1:0];
  assign op_f     = mem_rdata[IW_W-1:OP_LO];
  assign imm_f    = mem_rdata[IMM_B];
  assign fb_ext   = {{(DATA_W-ADDR_W){1'b0}}, fb_q};
  assign pc_inc   = pc_q + ADDR_W'(1);
  assign r1_addr  = r1_q[ADDR_W-1:0];
  assign bzj_tgt  = r1_q[ADDR_W-1:0];
  assign bzji_tgt = mem_rdata[ADDR_W-1:0] + fb_q;

  // run_q keeps the port idle while reset is held and for the first edge after it.
  assign go      = run_q && (state_q != S_HALT);
  assign acc     = go && mem_ack;
  assign halted  = (state_q == S_HALT);
  assign pc      = pc_q;

  always_comb begin
    alu_x   = imm_q ? fb_ext : r2_q;
    alu_res = '0;
    case (op_q)
      OP_ADD:  alu_res = r1_q + alu_x;
      OP_NAND: alu_res = ~(r1_q & alu_x);
      // Shift counts of DATA_W and above switch to a left shift by the excess.
      OP_SRL:  alu_res = (alu_x < DW_V) ? (r1_q >> alu_x) : (r1_q << (alu_x - DW_V));
      OP_LT:   alu_res = (r1_q < alu_x) ? DATA_W'(1) : '0;
`ifdef VSCPU_MUL_EN
      OP_MUL:  alu_res = r1_q * alu_x;
`endif
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    iw_d      = iw_q;
    r1_d      = r1_q;
    r2_d      = r2_q;
    mem_req   = go;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    retire    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_addr = pc_q;
        if (acc) begin
          iw_d = mem_rdata[IW_W-1:0];
          if (is_alu(op_f) || op_f == OP_CPI || op_f == OP_BZJ) begin
            state_d = S_RD1;
          end else if (op_f == OP_CP) begin
            state_d = imm_f ? S_WB : S_RD2;
          end else begin
            retire = 1'b1;
            pc_d   = pc_inc;
          end
        end
      end
      S_RD1: begin
        mem_addr = (op_q == OP_CPI && !imm_q) ? fb_q : fa_q;
        if (acc) begin
          r1_d = mem_rdata;
          if (op_q == OP_BZJ && imm_q) begin
            retire  = 1'b1;
            pc_d    = bzji_tgt;
            state_d = (bzji_tgt == pc_q) ? S_HALT : S_FETCH;
          end else if (op_q == OP_CPI && !imm_q) begin
            state_d = S_RD3;
          end else if (is_alu(op_q) && imm_q) begin
            state_d = S_WB;
          end else begin
            state_d = S_RD2;
          end
        end
      end
      S_RD2: begin
        mem_addr = fb_q;
        if (acc) begin
          r2_d = mem_rdata;
          if (op_q == OP_BZJ) begin
            retire = 1'b1;
            if (mem_rdata == '0) begin
              pc_d    = bzj_tgt;
              state_d = (bzj_tgt == pc_q) ? S_HALT : S_FETCH;
            end else begin
              pc_d    = pc_inc;
              state_d = S_FETCH;
            end
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_RD3: begin
        mem_addr = r1_addr;
        if (acc) begin
          r2_d    = mem_rdata;
          state_d = S_WB;
        end
      end
      S_WB: begin
        mem_we    = 1'b1;
        mem_addr  = (op_q == OP_CPI && imm_q) ? r1_addr : fa_q;
        mem_wdata = is_alu(op_q) ? alu_res :
                    (op_q == OP_CP && imm_q) ? fb_ext : r2_q;
        if (acc) begin
          retire  = 1'b1;
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      iw_q    <= '0;
      r1_q    <= '0;
      r2_q    <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      iw_q    <= iw_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      run_q   <= 1'b1;
    end
  end
endmodule
